// File: rtl/mm_bram_result_drain.sv
// mm_bram_result_drain
//
// Result-side endpoint of the parallel BRAM matrix-multiply datapath.
// Owns COL_NUM result banks (ROW_NUM x ACC_WIDTH each). It absorbs the
// per-column write bus from the multiplier while in FILL. Once every
// column has seen ROW_NUM writes, it reads the banks back one row at a
// time and streams each full row downstream over val/rdy. It then clears
// its tracking state and re-arms for the next matrix.
//
// Ports:
//   clk           - single clock, rising edge
//   reset         - synchronous, active-low
//   row_data_out  - write data, ACC_WIDTH slice c targets bank c
//   row_wraddr    - write row address, ROW_ADDR_WIDTH slice c targets bank c
//   row_wr_en     - per-bank write strobe
//   fill_rdy      - high while accepting a new matrix (FILL)
//   val_out       - out_data / out_row valid
//   rdy_out       - downstream accepts current row
//   out_data      - one result row, slice c = bank c
//   out_row       - row index of out_data
//   done          - one-cycle pulse after the last row is accepted
//   wr_err        - sticky, a write strobe arrived outside FILL

module mm_bram_result_drain #(
    parameter int DATA_WIDTH = 8,
    parameter int ROW_NUM    = 32,
    parameter int COL_NUM    = 32,
    localparam int ACC_WIDTH      = DATA_WIDTH * 4,
    localparam int ROW_ADDR_WIDTH = $clog2(ROW_NUM),
    localparam int CNT_WIDTH      = $clog2(ROW_NUM + 1)
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [ACC_WIDTH*COL_NUM-1:0]        row_data_out,
    input  logic [ROW_ADDR_WIDTH*COL_NUM-1:0]   row_wraddr,
    input  logic [COL_NUM-1:0]                  row_wr_en,
    output logic                                fill_rdy,
    output logic                                val_out,
    input  logic                                rdy_out,
    output logic [ACC_WIDTH*COL_NUM-1:0]        out_data,
    output logic [ROW_ADDR_WIDTH-1:0]           out_row,
    output logic                                done,
    output logic                                wr_err
);

    typedef enum logic [1:0] {
        FILL = 2'd0,
        RD   = 2'd1,
        OUT  = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0]      CNT_FULL = CNT_WIDTH'(ROW_NUM);
    localparam logic [ROW_ADDR_WIDTH-1:0] LAST_ROW = ROW_ADDR_WIDTH'(ROW_NUM - 1);

    state_t                    state;
    state_t                    state_n;
    logic [CNT_WIDTH-1:0]      cnt   [COL_NUM];
    logic [CNT_WIDTH-1:0]      cnt_n [COL_NUM];
    logic                      all_full_q;
    logic                      all_full_n;
    logic [ROW_ADDR_WIDTH-1:0] rd_row;
    logic                      in_fill;
    logic                      accept;
    logic                      last_accept;

    assign in_fill     = (state == FILL);
    assign accept      = (state == OUT) && rdy_out;
    assign last_accept = accept && (rd_row == LAST_ROW);
    assign out_row     = rd_row;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= FILL;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        val_out = 1'b0;
        case (state)
            FILL: begin
                if (all_full_q) begin
                    state_n = RD;
                end
            end
            RD: begin
                state_n = OUT;
            end
            OUT: begin
                val_out = 1'b1;
                if (accept) begin
                    state_n = last_accept ? FILL : RD;
                end
            end
            default: begin
                state_n = FILL;
            end
        endcase
    end

    // The all-complete flag is computed from the post-update counter
    // values so it registers on the same edge as the completing write.
    always_comb begin
        all_full_n = 1'b1;
        for (int c = 0; c < COL_NUM; c++) begin
            cnt_n[c] = cnt[c];
            if (last_accept) begin
                cnt_n[c] = '0;
            end else if (in_fill && row_wr_en[c] && (cnt[c] != CNT_FULL)) begin
                cnt_n[c] = cnt[c] + CNT_WIDTH'(1);
            end
            if (cnt_n[c] != CNT_FULL) begin
                all_full_n = 1'b0;
            end
        end
    end

    // fill_rdy tracks the next state so it is high exactly while in FILL.
    always_ff @(posedge clk) begin
        if (!reset) begin
            all_full_q <= 1'b0;
            rd_row     <= '0;
            done       <= 1'b0;
            wr_err     <= 1'b0;
            fill_rdy   <= 1'b1;
            for (int c = 0; c < COL_NUM; c++) begin
                cnt[c] <= '0;
            end
        end else begin
            all_full_q <= all_full_n;
            fill_rdy   <= (state_n == FILL);
            done       <= last_accept;
            if (!in_fill && (|row_wr_en)) begin
                wr_err <= 1'b1;
            end
            if (accept) begin
                rd_row <= last_accept ? '0 : rd_row + ROW_ADDR_WIDTH'(1);
            end
            for (int c = 0; c < COL_NUM; c++) begin
                cnt[c] <= cnt_n[c];
            end
        end
    end

    // One simple dual-port bank per column. The read register is loaded
    // only in RD, so out_data holds steady for as long as OUT is stalled.
    for (genvar c = 0; c < COL_NUM; c++) begin : g_bank
        logic [ACC_WIDTH-1:0]      mem [ROW_NUM];
        logic [ACC_WIDTH-1:0]      rd_q;
        logic [ROW_ADDR_WIDTH-1:0] wr_addr;

        assign wr_addr = row_wraddr[c*ROW_ADDR_WIDTH +: ROW_ADDR_WIDTH];

        always_ff @(posedge clk) begin
            if (reset && in_fill && row_wr_en[c]) begin
                mem[wr_addr] <= row_data_out[c*ACC_WIDTH +: ACC_WIDTH];
            end
            if (reset && (state == RD)) begin
                rd_q <= mem[rd_row];
            end
        end

        assign out_data[c*ACC_WIDTH +: ACC_WIDTH] = rd_q;
    end

endmodule

// File: tb/tb_mm_bram_result_drain.sv
// tb_mm_bram_result_drain
//
// Bench for mm_bram_result_drain with ROW_NUM=4, COL_NUM=2, DATA_WIDTH=8.
// A table of matrix scenarios is filled and drained. Expected rows are
// queued when a matrix is written and popped as the DUT hands rows out.
// Reset sequences are hand-written around the table.

module tb_mm_bram_result_drain;

    localparam int DW  = 8;
    localparam int RN  = 4;
    localparam int CN  = 2;
    localparam int AW  = DW * 4;
    localparam int RAW = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [AW*CN-1:0]  row_data_out;
    logic [RAW*CN-1:0] row_wraddr;
    logic [CN-1:0]     row_wr_en;
    logic              fill_rdy;
    logic              val_out;
    logic              rdy_out;
    logic [AW*CN-1:0]  out_data;
    logic [RAW-1:0]    out_row;
    logic              done;
    logic              wr_err;

    mm_bram_result_drain #(
        .DATA_WIDTH (DW),
        .ROW_NUM    (RN),
        .COL_NUM    (CN)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .row_data_out (row_data_out),
        .row_wraddr   (row_wraddr),
        .row_wr_en    (row_wr_en),
        .fill_rdy     (fill_rdy),
        .val_out      (val_out),
        .rdy_out      (rdy_out),
        .out_data     (out_data),
        .out_row      (out_row),
        .done         (done),
        .wr_err       (wr_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        int base;
        bit rev1;
        int skew;
        int stall_row;
        int stall_cycles;
        bit inject;
        int exp_rows;
        int exp_done;
        bit exp_wr_err;
    } vec_t;

    typedef struct {
        logic [RAW-1:0]   row;
        logic [AW*CN-1:0] data;
    } exp_t;

    vec_t vecs[5];
    exp_t sb[$];
    int   tests_run    = 0;
    int   tests_failed = 0;
    int   got_rows;
    int   got_done;

    function automatic logic [AW*CN-1:0] row_model(input int base, input int r);
        logic [AW*CN-1:0] d;
        d = '0;
        for (int c = 0; c < CN; c++) begin
            d[c*AW +: AW] = AW'(base + r * 16 + c);
        end
        return d;
    endfunction

    task automatic checkValue(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Drives one write cycle; entered and left at #1 after a rising edge.
    task automatic writeCycle(input logic [1:0] en, input int r0, input int r1, input int base);
        row_wr_en    = en;
        row_wraddr   = {2'(r1), 2'(r0)};
        row_data_out = {AW'(base + r1 * 16 + 1), AW'(base + r0 * 16)};
        @(posedge clk);
        #1;
        row_wr_en = '0;
    endtask

    task automatic fillMatrix(input vec_t v);
        int n;
        exp_t e;
        if (v.skew == 0) begin
            for (int r = 0; r < RN; r++) begin
                writeCycle(2'b11, r, v.rev1 ? (RN - 1 - r) : r, v.base);
            end
        end else begin
            for (int r = 0; r < RN; r++) begin
                writeCycle(2'b01, r, 0, v.base);
            end
            for (int k = 0; k < v.skew; k++) begin
                checkValue("no_val_during_skew", val_out, 0);
                @(posedge clk);
                #1;
            end
            for (int k = 0; k < RN; k++) begin
                checkValue("no_val_before_col1_done", val_out, 0);
                writeCycle(2'b10, 0, RN - 1 - k, v.base);
            end
        end
        n = 1;
        while (!val_out && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkValue("first_val_latency", n, 3);
        checkValue("fill_rdy_low_in_out", fill_rdy, 0);
        for (int r = 0; r < RN; r++) begin
            e.row  = RAW'(r);
            e.data = row_model(v.base, r);
            sb.push_back(e);
        end
    endtask

    task automatic drainMatrix(input vec_t v);
        int   stall_left;
        bit   started;
        bit   stalling;
        bit   inj;
        bit   seen_done;
        int   last_acc;
        int   budget;
        int   exp_gap;
        exp_t e;
        stall_left = v.stall_cycles;
        started    = 0;
        inj        = v.inject;
        seen_done  = 0;
        last_acc   = 0;
        budget     = 0;
        got_rows   = 0;
        got_done   = 0;
        while (!seen_done && budget < 300) begin
            stalling  = 0;
            rdy_out   = 1'b1;
            row_wr_en = '0;
            if (inj && val_out && got_rows == 1) begin
                rdy_out      = 1'b0;
                row_wr_en    = 2'b01;
                row_wraddr   = 4'b0011;
                row_data_out = 64'hDEAD_BEEF_DEAD_BEEF;
                inj          = 0;
            end else if (stall_left > 0 && got_rows == v.stall_row && (val_out || started)) begin
                rdy_out = 1'b0;
                started = 1;
                stall_left--;
                stalling = 1;
            end
            @(negedge clk);
            if (stalling) begin
                checkValue("stall_val_held", val_out, 1);
                checkValue("stall_row_held", out_row, v.stall_row);
                checkValue("stall_data_held", out_data, row_model(v.base, v.stall_row));
            end
            if (val_out && rdy_out) begin
                if (sb.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $display("[TB] FAIL unexpected_row: got row %0d, expected none", out_row);
                end else begin
                    e = sb.pop_front();
                    checkValue("row_index", out_row, e.row);
                    checkValue("row_data", out_data, e.data);
                end
                if (got_rows > 0) begin
                    exp_gap = 2;
                    if (got_rows == v.stall_row) exp_gap += v.stall_cycles;
                    if (v.inject && got_rows == 1) exp_gap += 1;
                    checkValue("row_gap", cyc - last_acc, exp_gap);
                end
                last_acc = cyc;
                got_rows++;
            end
            if (done) begin
                got_done++;
                seen_done = 1;
            end
            @(posedge clk);
            #1;
            budget++;
        end
        rdy_out   = 1'b0;
        row_wr_en = '0;
        if (!seen_done) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL done_timeout: got no done, expected done within 300 cycles");
        end
        checkValue("done_one_cycle", done, 0);
        checkValue("fill_rdy_after_done", fill_rdy, 1);
    endtask

    task automatic applyStimulus(input vec_t v);
        fillMatrix(v);
        drainMatrix(v);
    endtask

    task automatic checkOutput(input vec_t v);
        checkValue("rows_drained", got_rows, v.exp_rows);
        checkValue("done_pulses", got_done, v.exp_done);
        checkValue("wr_err", wr_err, v.exp_wr_err);
        checkValue("scoreboard_empty", sb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int   n;
        int   d;
        vec_t v;

        vecs[0] = '{base: 32'h0000, rev1: 0, skew: 0, stall_row: 99, stall_cycles: 0,
                    inject: 0, exp_rows: RN, exp_done: 1, exp_wr_err: 0};
        vecs[1] = '{base: 32'h1000, rev1: 1, skew: 5, stall_row: 99, stall_cycles: 0,
                    inject: 0, exp_rows: RN, exp_done: 1, exp_wr_err: 0};
        vecs[2] = '{base: 32'h2000, rev1: 0, skew: 0, stall_row: 2, stall_cycles: 7,
                    inject: 0, exp_rows: RN, exp_done: 1, exp_wr_err: 0};
        vecs[3] = '{base: 32'h3000, rev1: 0, skew: 0, stall_row: 99, stall_cycles: 0,
                    inject: 1, exp_rows: RN, exp_done: 1, exp_wr_err: 1};
        vecs[4] = '{base: 32'h4000, rev1: 1, skew: 0, stall_row: 99, stall_cycles: 0,
                    inject: 0, exp_rows: RN, exp_done: 1, exp_wr_err: 1};

        // Reset with random strobes on the write bus.
        reset   = 1'b0;
        rdy_out = 1'b0;
        for (int i = 0; i < 2; i++) begin
            row_wr_en    = 2'($urandom);
            row_wraddr   = 4'($urandom);
            row_data_out = {$urandom, $urandom};
            @(posedge clk);
            #1;
        end
        reset     = 1'b1;
        row_wr_en = '0;
        checkValue("reset_val_out", val_out, 0);
        checkValue("reset_done", done, 0);
        checkValue("reset_wr_err", wr_err, 0);
        checkValue("reset_fill_rdy", fill_rdy, 1);
        checkValue("reset_out_row", out_row, 0);

        for (int i = 0; i < 5; i++) begin
            applyStimulus(vecs[i]);
            checkOutput(vecs[i]);
        end

        // Reset while row 1 is being offered: matrix abandoned, no done.
        v = '{base: 32'h5000, rev1: 0, skew: 0, stall_row: 99, stall_cycles: 0,
              inject: 0, exp_rows: RN, exp_done: 1, exp_wr_err: 0};
        fillMatrix(v);
        sb.delete();
        rdy_out = 1'b1;
        @(posedge clk);
        #1;
        rdy_out = 1'b0;
        n = 0;
        while (!val_out && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkValue("mid_drain_val", val_out, 1);
        checkValue("mid_drain_row", out_row, 1);
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        checkValue("post_reset_fill_rdy", fill_rdy, 1);
        checkValue("post_reset_val_out", val_out, 0);
        checkValue("post_reset_out_row", out_row, 0);
        d = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done) d++;
        end
        @(posedge clk);
        #1;
        checkValue("no_done_after_reset", d, 0);
        checkValue("no_val_after_reset", val_out, 0);

        v.base = 32'h6000;
        applyStimulus(v);
        checkOutput(v);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
